// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate H/V counters, VGA syncs and blanking, line/frame strobes.
// Every output is a register on Clk; counters advance once every CLK_DIV Clk cycles.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hc_q, hc_d;
  logic [9:0]       vc_q, vc_d;
  logic             vga_clk_q, vga_clk_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_n_q, blank_n_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             pe, h_wrap, v_wrap;

  always_comb begin
    pe     = (div_q == DIV_LAST);
    h_wrap = pe && (hc_q == H_LAST);
    v_wrap = h_wrap && (vc_q == V_LAST);

    div_d = pe ? '0 : div_q + DIV_ONE;

    hc_d = hc_q;
    if (pe) begin
      hc_d = h_wrap ? '0 : hc_q + 10'd1;
    end

    vc_d = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + 10'd1;
    end

    // Decoded from next-state values so they line up with DrawX/DrawY.
    vga_clk_d     = (div_d >= DIV_HALF);
    hs_d          = !((hc_d >= HS_BEG) && (hc_d < HS_END));
    vs_d          = !((vc_d >= VS_BEG) && (vc_d < VS_END));
    blank_n_d     = (hc_d < H_VIS) && (vc_d < V_VIS);
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
    frame_count_d = v_wrap ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      vga_clk_q     <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      vga_clk_q     <= vga_clk_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign VGA_CLK     = vga_clk_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, tiny raster, CLK_DIV=4) checked by
// a closed-form raster model through per-instance scoreboard queues plus hand-computed milestones.
module tb_vga_timing_gen;

  typedef struct {
    int   k;
    logic vclk, hs, vs, blank, sync_n, ls, fs;
    int   x, y, fc;
  } exp_t;

  localparam int NCYC  = 43800;
  localparam int A_WIN = 3400;
  localparam int C_WIN = 7000;
  localparam int KMID  = 257 * 168 + (5 * 12 + 10) * 2;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  always #5 clk = ~clk;

  logic       a_vclk, a_hs, a_vs, a_blank, a_sync, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_vclk, b_hs, b_vs, b_blank, b_sync, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;
  logic       c_vclk, c_hs, c_vs, c_blank, c_sync, c_ls, c_fs;
  logic [9:0] c_x, c_y;
  logic [7:0] c_fc;

  vga_timing_gen u_a (
    .Clk(clk), .Reset(rst_a), .VGA_CLK(a_vclk), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_sync), .DrawX(a_x), .DrawY(a_y),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(2)
  ) u_b (
    .Clk(clk), .Reset(rst_b), .VGA_CLK(b_vclk), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_sync), .DrawX(b_x), .DrawY(b_y),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .CLK_DIV(4)
  ) u_c (
    .Clk(clk), .Reset(rst_c), .VGA_CLK(c_vclk), .VGA_HS(c_hs), .VGA_VS(c_vs),
    .VGA_BLANK_N(c_blank), .VGA_SYNC_N(c_sync), .DrawX(c_x), .DrawY(c_y),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
  );

  exp_t qa[$], qb[$], qc[$];
  int   n_chk = 0, n_fail = 0;

  // k = Clk edges since the last edge that sampled reset high.
  function automatic exp_t model(int k, int hv, int hf, int hsy, int hb,
                                 int vv, int vf, int vsy, int vb, int d);
    exp_t e;
    int   ht, vt, p, ph;
    ht = hv + hf + hsy + hb;
    vt = vv + vf + vsy + vb;
    p  = k / d;
    ph = k % d;
    e.k      = k;
    e.x      = p % ht;
    e.y      = (p / ht) % vt;
    e.vclk   = (ph >= d / 2);
    e.hs     = !(e.x >= hv + hf && e.x < hv + hf + hsy);
    e.vs     = !(e.y >= vv + vf && e.y < vv + vf + vsy);
    e.blank  = (e.x < hv) && (e.y < vv);
    e.sync_n = 1'b0;
    e.ls     = (ph == 0) && (p > 0) && (e.x == 0);
    e.fs     = (ph == 0) && (p > 0) && (p % (ht * vt) == 0);
    e.fc     = (k / (d * ht * vt)) % 256;
    return e;
  endfunction

  task automatic cmp(input string nm, input exp_t e, input logic vclk, input logic hs,
                     input logic vs, input logic bl, input logic sy, input logic [9:0] x,
                     input logic [9:0] y, input logic ls, input logic fs, input logic [7:0] fc);
    n_chk++;
    if (vclk !== e.vclk || hs !== e.hs || vs !== e.vs || bl !== e.blank || sy !== e.sync_n ||
        x !== 10'(e.x) || y !== 10'(e.y) || ls !== e.ls || fs !== e.fs || fc !== 8'(e.fc)) begin
      n_fail++;
      $display("FAIL %s k=%0d got clk=%b hs=%b vs=%b blank_n=%b sync_n=%b x=%0d y=%0d ls=%b fs=%b fc=%0d want clk=%b hs=%b vs=%b blank_n=%b sync_n=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
               nm, e.k, vclk, hs, vs, bl, sy, x, y, ls, fs, fc,
               e.vclk, e.hs, e.vs, e.blank, e.sync_n, e.x, e.y, e.ls, e.fs, e.fc);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Milestone measurements taken by the monitors from DUT outputs.
  int a_hs_low = 0, a_ls_cnt = 0, a_fs_cnt = 0, a_first_x1 = -1, a_bfall_k = -1, a_bfall_x = -1;
  int b_fs_cnt = 0, b_wrap_k = -1, b_prev_fc = -1, b_mid = -1;
  int c_first_ls = -1, c_first_x1 = -1;
  logic [3:0] c_pat = 4'b0000;

  exp_t ea, eb, ec;

  initial forever begin
    @(negedge clk);
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      cmp("line_default", ea, a_vclk, a_hs, a_vs, a_blank, a_sync, a_x, a_y, a_ls, a_fs, a_fc);
      if (ea.k < 1600 && !a_hs) a_hs_low++;
      if (a_ls) a_ls_cnt++;
      if (a_fs) a_fs_cnt++;
      if (a_x == 10'd1 && a_first_x1 < 0) a_first_x1 = ea.k;
      if (!a_blank && a_bfall_k < 0) begin
        a_bfall_k = ea.k;
        a_bfall_x = int'(a_x);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      cmp("frames_tiny", eb, b_vclk, b_hs, b_vs, b_blank, b_sync, b_x, b_y, b_ls, b_fs, b_fc);
      if (b_fs) b_fs_cnt++;
      if (b_prev_fc == 255 && b_fc == 8'd0 && b_wrap_k < 0) b_wrap_k = eb.k;
      b_prev_fc = int'(b_fc);
      if (eb.k == KMID && b_mid < 0) b_mid = int'({b_hs, b_vs, b_x, b_y});
    end
  end

  initial forever begin
    @(negedge clk);
    if (qc.size() > 0) begin
      ec = qc.pop_front();
      cmp("div4", ec, c_vclk, c_hs, c_vs, c_blank, c_sync, c_x, c_y, c_ls, c_fs, c_fc);
      if (c_ls && c_first_ls < 0) c_first_ls = ec.k;
      if (c_x == 10'd1 && c_first_x1 < 0) c_first_x1 = ec.k;
      if (ec.k >= 4 && ec.k <= 7) c_pat[ec.k-4] = c_vclk;
    end
  end

  initial begin
    int ka, kb, kc, b_left;
    bit b_done;
    ka = 0; kb = 0; kc = 0; b_left = 0; b_done = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      ka = rst_a ? 0 : ka + 1;
      kb = rst_b ? 0 : kb + 1;
      kc = rst_c ? 0 : kc + 1;
      if (c < A_WIN) qa.push_back(model(ka, 640, 16, 96, 48, 480, 10, 2, 33, 2));
      qb.push_back(model(kb, 8, 1, 2, 1, 4, 1, 1, 1, 2));
      if (c < C_WIN) qc.push_back(model(kc, 640, 16, 96, 48, 4, 1, 1, 1, 4));
      // Mid-frame reset on the tiny raster at DrawX=10, DrawY=5 (HS and VS both low).
      if (kb == KMID && !b_done) begin
        b_left = 2;
        b_done = 1;
      end
      rst_a = (c < 2);
      rst_c = (c < 2);
      rst_b = (c < 2) || (b_left > 0);
      if (b_left > 0) b_left--;
    end
    repeat (2) @(negedge clk);
    #1;
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    chk("queue_c_drained", qc.size(), 0);
    chk("a_first_drawx1_k", a_first_x1, 2);
    chk("a_hs_low_cycles", a_hs_low, 192);
    chk("a_blank_fall_k", a_bfall_k, 1280);
    chk("a_blank_fall_x", a_bfall_x, 640);
    chk("a_line_starts", a_ls_cnt, 2);
    chk("a_frame_starts", a_fs_cnt, 0);
    chk("b_fc_wrap_k", b_wrap_k, 43008);
    chk("b_frame_starts", b_fs_cnt, 259);
    chk("b_mid_hs_vs_x_y", b_mid, int'({1'b0, 1'b0, 10'd10, 10'd5}));
    chk("c_first_line_start_k", c_first_ls, 3200);
    chk("c_first_drawx1_k", c_first_x1, 4);
    chk("c_vga_clk_pattern", int'(c_pat), 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
